// File: rtl/rdma_wr_arbiter_pkg.sv
// Shared RDMA types for the write arbiter: request descriptor, sequence entry
// and bus widths.
package lynxTypes;

    localparam int unsigned LEN_BITS      = 28;
    localparam int unsigned VADDR_BITS    = 48;
    localparam int unsigned PID_BITS      = 6;
    localparam int unsigned DEST_BITS     = 4;
    localparam int unsigned AXI_NET_BITS  = 512;
    localparam int unsigned N_OUTSTANDING = 8;
    localparam int unsigned BEAT_SHIFT    = $clog2(AXI_NET_BITS / 8);
    localparam int unsigned CNT_BITS      = LEN_BITS - 5;
    localparam int unsigned SEQ_SRC_BITS  = 4;

    typedef struct packed {
        logic [VADDR_BITS-1:0] vaddr;
        logic [LEN_BITS-1:0]   len;
        logic [PID_BITS-1:0]   pid;
        logic [DEST_BITS-1:0]  dest;
        logic                  host;
        logic                  last;
    } req_t;

    localparam int unsigned REQ_BITS = $bits(req_t);

    typedef struct packed {
        logic [SEQ_SRC_BITS-1:0] src;
        logic [LEN_BITS-1:0]     len;
    } arb_seq_t;

    // Index of the final beat: ceil(len / beat_bytes) - 1, len must be non-zero.
    function automatic logic [CNT_BITS-1:0] calc_last_idx(input logic [LEN_BITS-1:0] len);
        logic [LEN_BITS-1:0] beats;
        beats = len >> BEAT_SHIFT;
        if (len[BEAT_SHIFT-1:0] == '0) begin
            beats = beats - 1'b1;
        end
        return CNT_BITS'(beats);
    endfunction

endpackage

// File: rtl/rdma_wr_arbiter_rr_arbiter.sv
// Round-robin arbiter: scans from the pointer upward, pointer moves past the
// winner only on ack.
module rr_arbiter #(
    parameter int unsigned N = 4,
    localparam int unsigned IDX_BITS = $clog2(N)
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic [N-1:0]        valid,
    input  logic                ack,
    output logic [IDX_BITS-1:0] grant_idx,
    output logic [N-1:0]        grant_oh,
    output logic                any_valid
);

    logic [IDX_BITS-1:0] ptr_q, ptr_d;
    logic                found;

    always_comb begin
        found     = 1'b0;
        grant_idx = ptr_q;
        for (int k = 0; k < int'(N); k++) begin
            int unsigned j;
            j = int'(ptr_q) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (!found && valid[j]) begin
                found     = 1'b1;
                grant_idx = IDX_BITS'(j);
            end
        end
        grant_oh = '0;
        if (found) begin
            grant_oh[grant_idx] = 1'b1;
        end
        any_valid = |valid;
    end

    always_comb begin
        ptr_d = ptr_q;
        if (ack) begin
            ptr_d = (int'(grant_idx) == int'(N) - 1) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/rdma_wr_arbiter.sv
// Shares one RDMA write command/data path among N_SRC regions.
// Optional tlast consistency check: define RDMA_WR_ARB_TLAST_CHECK_EN.
module rdma_wr_arbiter
    import lynxTypes::*;
#(
    parameter int unsigned N_SRC  = 4,
    parameter int unsigned QDEPTH = N_OUTSTANDING,
    localparam int unsigned SRC_BITS = $clog2(N_SRC)
) (
    input  logic                            aclk,
    input  logic                            aresetn,

    input  logic [N_SRC-1:0]                s_req_valid,
    output logic [N_SRC-1:0]                s_req_ready,
    input  logic [N_SRC*REQ_BITS-1:0]       s_req_data,

    output logic                            m_req_valid,
    input  logic                            m_req_ready,
    output logic [REQ_BITS-1:0]             m_req_data,

    input  logic [N_SRC-1:0]                s_axis_tvalid,
    output logic [N_SRC-1:0]                s_axis_tready,
    input  logic [N_SRC*AXI_NET_BITS-1:0]   s_axis_tdata,
    input  logic [N_SRC*AXI_NET_BITS/8-1:0] s_axis_tkeep,
    input  logic [N_SRC-1:0]                s_axis_tlast,

    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic [AXI_NET_BITS-1:0]         m_axis_tdata,
    output logic [AXI_NET_BITS/8-1:0]       m_axis_tkeep,
    output logic                            m_axis_tlast
`ifdef RDMA_WR_ARB_TLAST_CHECK_EN
    ,
    output logic                            err_tlast,
    output logic [SRC_BITS-1:0]             err_src
`endif
);

    localparam int unsigned PTR_BITS = $clog2(QDEPTH);

    typedef enum logic {ST_IDLE, ST_MUX} state_e;

    req_t                      req_arr   [N_SRC];
    logic [AXI_NET_BITS-1:0]   tdata_arr [N_SRC];
    logic [AXI_NET_BITS/8-1:0] tkeep_arr [N_SRC];

    for (genvar g = 0; g < N_SRC; g++) begin : g_split
        assign req_arr[g]   = req_t'(s_req_data[g*REQ_BITS +: REQ_BITS]);
        assign tdata_arr[g] = s_axis_tdata[g*AXI_NET_BITS +: AXI_NET_BITS];
        assign tkeep_arr[g] = s_axis_tkeep[g*(AXI_NET_BITS/8) +: AXI_NET_BITS/8];
    end

    // ---------------- command arbitration ----------------
    logic [SRC_BITS-1:0] grant_idx;
    logic [N_SRC-1:0]    grant_oh;
    logic                any_valid;
    req_t                grant_req;
    logic                len_zero, seq_ready, push_ok, req_hs, push;

    assign grant_req = req_arr[grant_idx];
    assign len_zero  = (grant_req.len == '0);
    // Zero-length commands carry no data, so they never need a queue slot.
    assign push_ok   = seq_ready | len_zero;

    assign m_req_valid = any_valid & push_ok;
    assign m_req_data  = grant_req;
    assign s_req_ready = (any_valid & m_req_ready & push_ok) ? grant_oh : '0;
    assign req_hs      = m_req_valid & m_req_ready;
    assign push        = req_hs & ~len_zero;

    rr_arbiter #(
        .N (N_SRC)
    ) u_rr_arbiter (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .valid     (s_req_valid),
        .ack       (req_hs),
        .grant_idx (grant_idx),
        .grant_oh  (grant_oh),
        .any_valid (any_valid)
    );

    // ---------------- sequence queue ----------------
    arb_seq_t            mem_q [QDEPTH];
    arb_seq_t            push_entry, q_head;
    logic [PTR_BITS:0]   wr_ptr_q, rd_ptr_q;
    logic                q_empty, q_full, pop;

    assign push_entry.src = SEQ_SRC_BITS'(grant_idx);
    assign push_entry.len = grant_req.len;

    assign q_empty   = (wr_ptr_q == rd_ptr_q);
    assign q_full    = (wr_ptr_q[PTR_BITS] != rd_ptr_q[PTR_BITS]) &&
                       (wr_ptr_q[PTR_BITS-1:0] == rd_ptr_q[PTR_BITS-1:0]);
    assign seq_ready = ~q_full;
    assign q_head    = mem_q[rd_ptr_q[PTR_BITS-1:0]];

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge aclk) begin
        if (push) begin
            mem_q[wr_ptr_q[PTR_BITS-1:0]] <= push_entry;
        end
    end

    // ---------------- data steering FSM ----------------
    state_e              state_q, state_d;
    logic [SRC_BITS-1:0] src_q, src_d;
    logic [CNT_BITS-1:0] last_q, last_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic                beat_last, beat_hs;

    assign beat_last = (cnt_q == last_q);
    assign beat_hs   = (state_q == ST_MUX) & s_axis_tvalid[src_q] & m_axis_tready;

    assign m_axis_tdata = tdata_arr[src_q];
    assign m_axis_tkeep = tkeep_arr[src_q];

    always_comb begin
        state_d       = state_q;
        src_d         = src_q;
        last_d        = last_q;
        cnt_d         = cnt_q;
        pop           = 1'b0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        s_axis_tready = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (!q_empty) begin
                    pop     = 1'b1;
                    src_d   = SRC_BITS'(q_head.src);
                    last_d  = calc_last_idx(q_head.len);
                    cnt_d   = '0;
                    state_d = ST_MUX;
                end
            end
            ST_MUX: begin
                m_axis_tvalid        = s_axis_tvalid[src_q];
                m_axis_tlast         = beat_last;
                s_axis_tready[src_q] = m_axis_tready;
                if (beat_hs) begin
                    cnt_d = cnt_q + 1'b1;
                    if (beat_last) begin
                        // Back-to-back bursts: reload in the same cycle, no bubble.
                        if (!q_empty) begin
                            pop    = 1'b1;
                            src_d  = SRC_BITS'(q_head.src);
                            last_d = calc_last_idx(q_head.len);
                            cnt_d  = '0;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= ST_IDLE;
            src_q   <= '0;
            last_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef RDMA_WR_ARB_TLAST_CHECK_EN
    logic                err_tlast_q;
    logic [SRC_BITS-1:0] err_src_q;

    // Sticky: only the first offending source is recorded.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            err_tlast_q <= 1'b0;
            err_src_q   <= '0;
        end else if (beat_hs && (s_axis_tlast[src_q] != beat_last) && !err_tlast_q) begin
            err_tlast_q <= 1'b1;
            err_src_q   <= src_q;
        end
    end

    assign err_tlast = err_tlast_q;
    assign err_src   = err_src_q;
`else
    logic unused_tlast;
    assign unused_tlast = ^s_axis_tlast;
`endif

endmodule

// File: tb/tb_rdma_wr_arbiter.sv
// Self-checking bench for rdma_wr_arbiter: directed table, corner sequences and
// randomized traffic against a request/beat scoreboard.
module tb_rdma_wr_arbiter;
    import lynxTypes::*;

    localparam int unsigned NS = 4;
    localparam int unsigned QD = 8;
    localparam int unsigned DB = AXI_NET_BITS;
    localparam int unsigned KB = AXI_NET_BITS / 8;

    logic                 aclk = 1'b0;
    logic                 aresetn;
    logic [NS-1:0]        s_req_valid, s_req_ready;
    logic [NS*REQ_BITS-1:0] s_req_data;
    logic                 m_req_valid, m_req_ready;
    logic [REQ_BITS-1:0]  m_req_data;
    logic [NS-1:0]        s_axis_tvalid, s_axis_tready, s_axis_tlast;
    logic [NS*DB-1:0]     s_axis_tdata;
    logic [NS*KB-1:0]     s_axis_tkeep;
    logic                 m_axis_tvalid, m_axis_tready, m_axis_tlast;
    logic [DB-1:0]        m_axis_tdata;
    logic [KB-1:0]        m_axis_tkeep;
`ifdef RDMA_WR_ARB_TLAST_CHECK_EN
    logic                 err_tlast;
    logic [1:0]           err_src;
`endif

    req_t          req_in   [NS];
    logic [DB-1:0] tdata_in [NS];
    logic [KB-1:0] tkeep_in [NS];

    for (genvar g = 0; g < NS; g++) begin : g_pack
        assign s_req_data[g*REQ_BITS +: REQ_BITS] = req_in[g];
        assign s_axis_tdata[g*DB +: DB]           = tdata_in[g];
        assign s_axis_tkeep[g*KB +: KB]           = tkeep_in[g];
    end

    always #5 aclk = ~aclk;

    rdma_wr_arbiter #(
        .N_SRC  (NS),
        .QDEPTH (QD)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_req_valid   (s_req_valid),
        .s_req_ready   (s_req_ready),
        .s_req_data    (s_req_data),
        .m_req_valid   (m_req_valid),
        .m_req_ready   (m_req_ready),
        .m_req_data    (m_req_data),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast)
`ifdef RDMA_WR_ARB_TLAST_CHECK_EN
        ,
        .err_tlast     (err_tlast),
        .err_src       (err_src)
`endif
    );

    // ---------------- bench state ----------------
    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int mr_pct, ma_pct, sv_pct, rq_pct;
    int bad_tlast_src = -1;
    int model_ptr;

    int pend_len      [NS][$];
    int burst_q       [NS][$];
    int beat_in_burst [NS];
    int gen_cnt       [NS];
    int src_cnt       [NS];

    typedef struct {
        int src;
        int data;
        bit last;
    } beat_t;
    beat_t exp_q[$];

    int grant_log[$];
    int grant_cyc[$];
    int beat_src_log[$];
    int beat_cyc[$];
    bit beat_last_log[$];

    typedef struct {
        int src;
        int len;
        int beats;
    } vec_t;
    vec_t vecs[8];

    task automatic chk(input string nm, input logic [DB-1:0] act, input logic [DB-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [DB-1:0] mk_data(input int s, input int c);
        logic [DB-1:0] d;
        d            = '0;
        d[31:0]      = 32'(c);
        d[39:32]     = 8'(s);
        d[DB-1:DB-32] = 32'(c * 7 + s);
        return d;
    endfunction

    function automatic logic [KB-1:0] mk_keep(input int s, input int c);
        logic [KB-1:0] k;
        k[63:56] = 8'(s);
        k[55:32] = 24'(c);
        k[31:0]  = ~32'(c);
        return k;
    endfunction

    function automatic logic [NS-1:0] onehot(input int s);
        logic [NS-1:0] v;
        v    = '0;
        v[s] = 1'b1;
        return v;
    endfunction

    function automatic bit roll(input int pct);
        return int'($urandom_range(99)) < pct;
    endfunction

    // Reference round-robin: first valid source at or after the pointer.
    function automatic int model_grant(input logic [NS-1:0] v);
        for (int k = 0; k < int'(NS); k++) begin
            int j;
            j = (model_ptr + k) % NS;
            if (v[j]) return j;
        end
        return -1;
    endfunction

    task automatic drive();
        for (int i = 0; i < int'(NS); i++) begin
            req_t r;
            r       = '0;
            r.vaddr = 48'({$urandom(), $urandom()});
            r.pid   = 6'(i);
            if (pend_len[i].size() > 0) r.len = LEN_BITS'(pend_len[i][0]);
            req_in[i]      = r;
            s_req_valid[i] = (pend_len[i].size() > 0) && roll(rq_pct);
            tdata_in[i]    = mk_data(i, src_cnt[i]);
            tkeep_in[i]    = mk_keep(i, src_cnt[i]);
            if (burst_q[i].size() > 0) begin
                s_axis_tvalid[i] = roll(sv_pct);
                if (i == bad_tlast_src) s_axis_tlast[i] = (beat_in_burst[i] == 0);
                else s_axis_tlast[i] = (beat_in_burst[i] == burst_q[i][0] - 1);
            end else begin
                s_axis_tvalid[i] = 1'b0;
                s_axis_tlast[i]  = 1'b0;
            end
        end
        m_req_ready   = roll(mr_pct);
        m_axis_tready = roll(ma_pct);
    endtask

    task automatic sample();
        int    g, nb, len;
        beat_t e;
        if (m_req_valid && m_req_ready) begin
            g = model_grant(s_req_valid);
            chk("req_has_valid", (g >= 0), 1);
            if (g >= 0) begin
                chk("req_ready_onehot", s_req_ready, onehot(g));
                chk("req_data", m_req_data, req_in[g]);
                len = pend_len[g].pop_front();
                grant_log.push_back(g);
                grant_cyc.push_back(cyc);
                model_ptr = (g + 1) % NS;
                nb = (len + 63) / 64;
                if (nb > 0) burst_q[g].push_back(nb);
                for (int k = 0; k < nb; k++) begin
                    exp_q.push_back('{src: g, data: gen_cnt[g], last: (k == nb - 1)});
                    gen_cnt[g]++;
                end
            end
        end else begin
            chk("req_ready_idle", s_req_ready, 0);
        end

        if (s_axis_tready != '0) begin
            if (exp_q.size() == 0) chk("tready_no_burst", s_axis_tready, 0);
            else chk("tready_sel", s_axis_tready, m_axis_tready ? onehot(exp_q[0].src) : '0);
        end

        if (m_axis_tvalid && m_axis_tready) begin
            if (exp_q.size() == 0) begin
                chk("beat_unexpected", m_axis_tvalid, 0);
            end else begin
                e = exp_q.pop_front();
                chk("beat_data", m_axis_tdata, mk_data(e.src, e.data));
                chk("beat_keep", m_axis_tkeep, mk_keep(e.src, e.data));
                chk("beat_last", m_axis_tlast, e.last);
                chk("beat_src_hs", s_axis_tready & s_axis_tvalid, onehot(e.src));
                beat_src_log.push_back(e.src);
                beat_cyc.push_back(cyc);
                beat_last_log.push_back(e.last);
                src_cnt[e.src]++;
                beat_in_burst[e.src]++;
                if (burst_q[e.src].size() > 0 && beat_in_burst[e.src] == burst_q[e.src][0]) begin
                    void'(burst_q[e.src].pop_front());
                    beat_in_burst[e.src] = 0;
                end
            end
        end
    endtask

    task automatic step();
        @(negedge aclk);
        sample();
        @(posedge aclk);
        cyc++;
        #1;
        drive();
    endtask

    function automatic bit busy();
        if (exp_q.size() != 0) return 1'b1;
        for (int i = 0; i < int'(NS); i++) begin
            if (pend_len[i].size() != 0 || burst_q[i].size() != 0) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic run_idle(input int budget, input string nm);
        int n;
        n = 0;
        while (busy() && n < budget) begin
            step();
            n++;
        end
        if (busy()) chk({nm, "_timeout"}, 1, 0);
        repeat (3) step();
    endtask

    task automatic clear_logs();
        grant_log.delete();
        grant_cyc.delete();
        beat_src_log.delete();
        beat_cyc.delete();
        beat_last_log.delete();
    endtask

    task automatic set_pct(input int mr, input int ma, input int sv, input int rq);
        mr_pct = mr;
        ma_pct = ma;
        sv_pct = sv;
        rq_pct = rq;
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        for (int i = 0; i < int'(NS); i++) begin
            pend_len[i].delete();
            burst_q[i].delete();
            beat_in_burst[i] = 0;
            gen_cnt[i]       = 0;
            src_cnt[i]       = 0;
            req_in[i]        = '0;
            tdata_in[i]      = '0;
            tkeep_in[i]      = '0;
        end
        exp_q.delete();
        clear_logs();
        model_ptr     = 0;
        bad_tlast_src = -1;
        s_req_valid   = '0;
        s_axis_tvalid = '0;
        s_axis_tlast  = '0;
        m_req_ready   = 1'b0;
        m_axis_tready = 1'b0;
        #1;
        chk("rst_m_axis_tvalid", m_axis_tvalid, 0);
        chk("rst_s_axis_tready", s_axis_tready, 0);
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        drive();
    endtask

    initial begin
        int nb_beats, nb_last, g0, b0, first_last;

        vecs[0] = '{src: 0, len: 128,  beats: 2};
        vecs[1] = '{src: 3, len: 65,   beats: 2};
        vecs[2] = '{src: 1, len: 0,    beats: 0};
        vecs[3] = '{src: 2, len: 64,   beats: 1};
        vecs[4] = '{src: 1, len: 1,    beats: 1};
        vecs[5] = '{src: 0, len: 4096, beats: 64};
        vecs[6] = '{src: 3, len: 4097, beats: 65};
        vecs[7] = '{src: 2, len: 127,  beats: 2};

        set_pct(100, 100, 100, 100);
        do_reset();
        chk("reset_m_req_valid", m_req_valid, 0);
        chk("reset_s_req_ready", s_req_ready, 0);
        chk("reset_m_axis_tvalid", m_axis_tvalid, 0);
        chk("reset_s_axis_tready", s_axis_tready, 0);
`ifdef RDMA_WR_ARB_TLAST_CHECK_EN
        chk("reset_err_tlast", err_tlast, 0);
`endif

        // Three simultaneous single-beat requests: grants 0,1,2, back-to-back data.
        for (int i = 0; i < 3; i++) pend_len[i].push_back(64);
        drive();
        run_idle(200, "three");
        chk("three_grants", grant_log.size(), 3);
        chk("three_beats", beat_src_log.size(), 3);
        if (grant_log.size() >= 3 && beat_src_log.size() >= 3) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("three_grant%0d", i), grant_log[i], i);
                chk($sformatf("three_beat_src%0d", i), beat_src_log[i], i);
            end
            chk("three_no_bubble01", beat_cyc[1] - beat_cyc[0], 1);
            chk("three_no_bubble12", beat_cyc[2] - beat_cyc[1], 1);
        end

        // Pointer now sits at 3: with every source requesting, 3 wins first.
        for (int i = 0; i < int'(NS); i++) pend_len[i].push_back(64);
        drive();
        run_idle(200, "rr");
        if (grant_log.size() >= 4) chk("rr_after_three", grant_log[3], 3);
        else chk("rr_grant_count", grant_log.size(), 7);

        // Directed single transfers.
        for (int v = 0; v < 8; v++) begin
            g0 = grant_log.size();
            b0 = beat_src_log.size();
            pend_len[vecs[v].src].push_back(vecs[v].len);
            drive();
            run_idle(500, $sformatf("vec%0d", v));
            nb_beats = 0;
            nb_last  = 0;
            for (int k = b0; k < beat_src_log.size(); k++) begin
                if (beat_src_log[k] == vecs[v].src) nb_beats++;
                if (beat_last_log[k]) nb_last++;
            end
            chk($sformatf("vec%0d_grants", v), grant_log.size() - g0, 1);
            chk($sformatf("vec%0d_beats", v), nb_beats, vecs[v].beats);
            chk($sformatf("vec%0d_total_beats", v), beat_src_log.size() - b0, vecs[v].beats);
            chk($sformatf("vec%0d_tlasts", v), nb_last, (vecs[v].beats > 0) ? 1 : 0);
        end

        // Queue full: one entry is held by the data FSM, so QD+1 commands fit.
        set_pct(100, 0, 100, 100);
        do_reset();
        for (int k = 0; k < 10; k++) pend_len[k % NS].push_back(128);
        drive();
        repeat (30) step();
        chk("full_accepts", grant_log.size(), QD + 1);
        chk("full_m_req_valid", m_req_valid, 0);
        chk("full_s_req_ready", s_req_ready, 0);
        ma_pct = 100;
        drive();
        run_idle(500, "full");
        chk("full_all_accepted", grant_log.size(), 10);
        first_last = -1;
        for (int k = 0; k < beat_last_log.size(); k++) begin
            if (first_last < 0 && beat_last_log[k]) first_last = beat_cyc[k];
        end
        if (grant_cyc.size() >= 10) chk("full_release_after_burst", grant_cyc[9] > first_last, 1);

        // Reset mid-transfer: nothing must come out afterwards.
        set_pct(100, 100, 100, 100);
        do_reset();
        pend_len[1].push_back(4096);
        drive();
        repeat (10) step();
        chk("midrst_started", beat_src_log.size() > 0, 1);
        do_reset();
        for (int k = 0; k < 5; k++) begin
            step();
            chk($sformatf("midrst_quiet%0d", k), m_axis_tvalid, 0);
        end

        // Randomized traffic with backpressure everywhere.
        set_pct(70, 60, 80, 70);
        do_reset();
        for (int k = 0; k < 200; k++) begin
            pend_len[$urandom_range(NS - 1)].push_back(int'($urandom_range(4096, 1)));
        end
        drive();
        run_idle(60000, "random");
        chk("random_grants", grant_log.size(), 200);

`ifdef RDMA_WR_ARB_TLAST_CHECK_EN
        set_pct(100, 100, 100, 100);
        do_reset();
        bad_tlast_src = 2;
        pend_len[2].push_back(128);
        drive();
        run_idle(200, "tlast");
        chk("err_tlast_set", err_tlast, 1);
        chk("err_src", err_src, 2);
        repeat (5) step();
        chk("err_tlast_sticky", err_tlast, 1);
        do_reset();
        chk("err_tlast_cleared", err_tlast, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
